// File: rtl/ahb_sram_pkg.sv
// ahb_sram_pkg: shared AHB codes, FSM states and decode helper for the AHB SRAM slave
package ahb_sram_pkg;
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  typedef enum logic [2:0] {ST_IDLE, ST_WR, ST_RD_WAIT, ST_RD_DATA, ST_ERR1, ST_ERR2} state_t;
  // a single bank still needs a 1-bit field so port widths stay legal
  function automatic int bank_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ahb_sram_lane_dec.sv
// ahb_sram_lane_dec: per-bank byte-lane chip selects from bank, byte offset and transfer size
module ahb_sram_lane_dec
  import ahb_sram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BANKS  = 2
) (
  input  logic                                  en,
  input  logic [bank_w(NUM_BANKS)-1:0]          bank,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]       off,
  input  logic [2:0]                            size,
  output logic [NUM_BANKS*DATA_WIDTH/8-1:0]     cs
);
  localparam int LANES = DATA_WIDTH / 8;
  localparam int CSW   = NUM_BANKS * LANES;
  logic [LANES-1:0] lanes;
  // 2^size contiguous lanes from the offset; a full-width access yields all lanes at offset 0
  assign lanes = LANES'(((1 << (1 << size)) - 1) << off);
  assign cs = en ? CSW'(lanes) << (int'(bank) * LANES) : '0;
endmodule

// File: rtl/ahb_sram_slave_param.sv
// ahb_sram_slave_param: AHB-Lite slave fronting NUM_BANKS byte-laned SRAM banks with configurable read latency
module ahb_sram_slave_param
  import ahb_sram_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int SRAM_ADDR_WIDTH = 13,
  parameter int NUM_BANKS       = 2,
  parameter int RD_LATENCY      = 1
) (
  input  logic                              hclk,
  input  logic                              hreset,
  input  logic                              hsel,
  input  logic [ADDR_WIDTH-1:0]             haddr,
  input  logic [1:0]                        htrans,
  input  logic                              hwrite,
  input  logic [2:0]                        hsize,
  input  logic [2:0]                        hburst,
  input  logic [DATA_WIDTH-1:0]             hwdata,
  input  logic                              hready,
  output logic [DATA_WIDTH-1:0]             hrdata,
  output logic [1:0]                        hresp,
  output logic                              hready_resp,
  output logic [NUM_BANKS*DATA_WIDTH/8-1:0] sram_cs,
  output logic                              sram_we,
  output logic [SRAM_ADDR_WIDTH-1:0]        sram_addr,
  output logic [DATA_WIDTH-1:0]             sram_wdata,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]   sram_rdata
);
  localparam int OFF_W  = $clog2(DATA_WIDTH / 8);
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int BW     = bank_w(NUM_BANKS);
  localparam int TOT    = OFF_W + SRAM_ADDR_WIDTH + BANK_W;
  state_t state, state_nxt;
  logic [1:0] cnt;
  logic [SRAM_ADDR_WIDTH-1:0] word_q;
  logic [BW-1:0] bank_q;
  logic [OFF_W-1:0] off_q;
  logic [2:0] size_q;
  logic [ADDR_WIDTH-1:0] align_mask;
  logic cap, bad, cs_en, unused_burst;
  // bursts are decoded beat by beat from haddr, so hburst carries no information here
  assign unused_burst = ^hburst;
  assign cap = hsel && hready && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
  assign align_mask = (ADDR_WIDTH'(1) << hsize) - ADDR_WIDTH'(1);
  assign bad = hsize > 3'(OFF_W) || (haddr & align_mask) != '0 || (haddr >> TOT) != '0;
  assign sram_addr = word_q;
  assign sram_wdata = hwdata;
  always_ff @(posedge hclk)
    if (hreset) begin
      state <= ST_IDLE;
      cnt <= '0;
      word_q <= '0;
      bank_q <= '0;
      off_q <= '0;
      size_q <= '0;
    end else begin
      state <= state_nxt;
      cnt <= state == ST_RD_WAIT ? cnt + 2'd1 : '0;
      if (cap) begin
        word_q <= SRAM_ADDR_WIDTH'(haddr >> OFF_W);
        bank_q <= NUM_BANKS == 1 ? '0 : BW'(haddr >> (OFF_W + SRAM_ADDR_WIDTH));
        off_q <= OFF_W'(haddr);
        size_q <= hsize;
      end
    end
  // ready states fall through to the capture decode so transfers pipeline back to back
  always_comb begin
    state_nxt = state;
    cs_en = 1'b0;
    sram_we = 1'b0;
    hresp = RESP_OKAY;
    hready_resp = 1'b1;
    hrdata = '0;
    case (state)
      ST_WR: begin
        cs_en = 1'b1;
        sram_we = 1'b1;
      end
      ST_RD_WAIT: begin
        cs_en = cnt == '0;
        hready_resp = 1'b0;
      end
      ST_RD_DATA: hrdata = sram_rdata[int'(bank_q) * DATA_WIDTH +: DATA_WIDTH];
      ST_ERR1: begin
        hresp = RESP_ERROR;
        hready_resp = 1'b0;
      end
      ST_ERR2: hresp = RESP_ERROR;
      default: ;
    endcase
    state_nxt = state == ST_RD_WAIT ? (cnt == 2'(RD_LATENCY - 1) ? ST_RD_DATA : ST_RD_WAIT)
              : state == ST_ERR1 ? ST_ERR2
              : !cap ? ST_IDLE
              : bad ? ST_ERR1
              : hwrite ? ST_WR : ST_RD_WAIT;
  end
  ahb_sram_lane_dec #(.DATA_WIDTH(DATA_WIDTH), .NUM_BANKS(NUM_BANKS)) u_lane_dec (
    .en(cs_en),
    .bank(bank_q),
    .off(off_q),
    .size(size_q),
    .cs(sram_cs)
  );
endmodule

// File: tb/tb_ahb_sram_slave_param.sv
// tb_ahb_sram_slave_param: directed checks of the AHB SRAM slave at read latency 1 and 3
module tb_ahb_sram_slave_param;
  import ahb_sram_pkg::*;
  logic hclk, hreset, preload;
  logic hsel0, hsel1, hwrite;
  logic [31:0] haddr, hwdata;
  logic [1:0] htrans;
  logic [2:0] hsize, hburst;
  logic [31:0] hrdata0, hrdata1, wdata0, wdata1;
  logic [1:0] hresp0, hresp1;
  logic rdy0, rdy1, we0, we1;
  logic [7:0] cs0, cs1;
  logic [12:0] addr0, addr1;
  logic [63:0] rd0, rd1, p1a, p1b;
  logic [31:0] m0 [2][8192];
  logic [31:0] m1 [2][8192];
  int n_asserts = 0;
  int n_fail = 0;

  ahb_sram_slave_param u0 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(rdy0),
    .hrdata(hrdata0), .hresp(hresp0), .hready_resp(rdy0), .sram_cs(cs0), .sram_we(we0),
    .sram_addr(addr0), .sram_wdata(wdata0), .sram_rdata(rd0)
  );
  ahb_sram_slave_param #(.RD_LATENCY(3)) u1 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(rdy1),
    .hrdata(hrdata1), .hresp(hresp1), .hready_resp(rdy1), .sram_cs(cs1), .sram_we(we1),
    .sram_addr(addr1), .sram_wdata(wdata1), .sram_rdata(rd1)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    for (int l = 0; l < 4; l++) if (be[l]) o[l*8 +: 8] = n[l*8 +: 8];
    return o;
  endfunction

  // latency-1 SRAM model
  always @(posedge hclk)
    for (int b = 0; b < 2; b++)
      if (|cs0[b*4 +: 4]) begin
        if (we0) m0[b][addr0] <= merge(m0[b][addr0], wdata0, cs0[b*4 +: 4]);
        else rd0[b*32 +: 32] <= m0[b][addr0];
      end

  // latency-3 SRAM model with preload
  always @(posedge hclk) begin
    for (int b = 0; b < 2; b++) begin
      p1a[b*32 +: 32] <= (|cs1[b*4 +: 4] && !we1) ? m1[b][addr1] : 32'h0;
      if (|cs1[b*4 +: 4] && we1) m1[b][addr1] <= merge(m1[b][addr1], wdata1, cs1[b*4 +: 4]);
    end
    if (preload) for (int i = 0; i < 4; i++) m1[0][i] <= 32'hC0DE_0000 + i;
    p1b <= p1a;
    rd1 <= p1b;
  end

  task automatic nx;
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    hreset = 1; preload = 1; hsel0 = 0; hsel1 = 0; htrans = HTRANS_IDLE;
    haddr = 0; hwrite = 0; hsize = 0; hburst = 0; hwdata = 0;
    nx(); nx();
    hreset = 0; preload = 0; #1;
    chk("rst_ready", rdy0, 1); chk("rst_resp", hresp0, 0); chk("rst_rdata", hrdata0, 0);
    chk("rst_cs", cs0, 0); chk("rst_we", we0, 0);
    // word write then read back, pipelined
    hsel0 = 1; haddr = 32'h10; htrans = HTRANS_NONSEQ; hwrite = 1; hsize = 2;
    nx();
    hwdata = 32'hA5A5_1234; hwrite = 0; #1;
    chk("wr_ready", rdy0, 1); chk("wr_we", we0, 1); chk("wr_cs", cs0, 8'h0F);
    chk("wr_addr", addr0, 4); chk("wr_wdata", wdata0, 32'hA5A5_1234); chk("wr_resp", hresp0, 0);
    nx();
    hsel0 = 0; htrans = HTRANS_IDLE; #1;
    chk("rdw_ready", rdy0, 0); chk("rdw_cs", cs0, 8'h0F); chk("rdw_we", we0, 0);
    nx(); #1;
    chk("rdd_ready", rdy0, 1); chk("rdd_data", hrdata0, 32'hA5A5_1234); chk("rdd_resp", hresp0, 0);
    nx(); #1;
    chk("idle_cs", cs0, 0); chk("idle_rdata", hrdata0, 0);
    // word then byte write to bank 1, read back
    hsel0 = 1; haddr = 32'h8000; htrans = HTRANS_NONSEQ; hwrite = 1; hsize = 2;
    nx();
    hwdata = 32'h1122_3344; haddr = 32'h8003; hsize = 0; #1;
    chk("b1_word_cs", cs0, 8'hF0);
    nx();
    hwdata = 32'hEE00_0000; haddr = 32'h8000; hsize = 2; hwrite = 0; #1;
    chk("b1_byte_cs", cs0, 8'h80); chk("b1_byte_we", we0, 1); chk("b1_byte_addr", addr0, 0);
    nx();
    hsel0 = 0; htrans = HTRANS_IDLE; #1;
    chk("b1_rd_cs", cs0, 8'hF0);
    nx(); #1;
    chk("b1_rd_data", hrdata0, 32'hEE22_3344);
    nx();
    // misaligned halfword, then out-of-range issued from ERR2
    hsel0 = 1; htrans = HTRANS_NONSEQ; haddr = 32'h1; hsize = 1; hwrite = 0;
    nx();
    hsel0 = 0; htrans = HTRANS_IDLE; #1;
    chk("mis_e1_resp", hresp0, 1); chk("mis_e1_ready", rdy0, 0); chk("mis_e1_cs", cs0, 0);
    nx();
    hsel0 = 1; htrans = HTRANS_NONSEQ; haddr = 32'h0001_0000; hsize = 2; #1;
    chk("mis_e2_resp", hresp0, 1); chk("mis_e2_ready", rdy0, 1); chk("mis_e2_cs", cs0, 0);
    nx();
    hsel0 = 0; htrans = HTRANS_IDLE; #1;
    chk("oor_e1_resp", hresp0, 1); chk("oor_e1_ready", rdy0, 0); chk("oor_e1_cs", cs0, 0);
    nx(); #1;
    chk("oor_e2_resp", hresp0, 1); chk("oor_e2_ready", rdy0, 1);
    nx(); #1;
    chk("oor_idle_resp", hresp0, 0); chk("oor_idle_ready", rdy0, 1);
    // BUSY is never captured
    hsel0 = 1; htrans = HTRANS_BUSY; haddr = 32'h0001_0000;
    nx();
    hsel0 = 0; htrans = HTRANS_IDLE; #1;
    chk("busy_resp", hresp0, 0); chk("busy_ready", rdy0, 1); chk("busy_cs", cs0, 0);
    // size wider than the bus
    hsel0 = 1; htrans = HTRANS_NONSEQ; haddr = 0; hsize = 3;
    nx();
    hsel0 = 0; htrans = HTRANS_IDLE; hsize = 2; #1;
    chk("size_e1_resp", hresp0, 1); chk("size_e1_cs", cs0, 0);
    nx(); nx();
    // reset during RD_WAIT
    hsel0 = 1; htrans = HTRANS_NONSEQ; haddr = 32'h10; hwrite = 0;
    nx();
    hsel0 = 0; htrans = HTRANS_IDLE; hreset = 1; #1;
    chk("rstw_ready", rdy0, 0);
    nx();
    hreset = 0; #1;
    chk("rsta_ready", rdy0, 1); chk("rsta_cs", cs0, 0); chk("rsta_rdata", hrdata0, 0);
    hsel0 = 1; htrans = HTRANS_NONSEQ; haddr = 32'h10;
    nx();
    hsel0 = 0; htrans = HTRANS_IDLE;
    nx(); #1;
    chk("post_rst_ready", rdy0, 1); chk("post_rst_data", hrdata0, 32'hA5A5_1234);
    nx();
    // latency-3 INCR4 burst: three wait cycles then data per beat
    hsel1 = 1; htrans = HTRANS_NONSEQ; haddr = 0; hburst = 3'b011; hsize = 2; hwrite = 0;
    nx();
    for (int i = 0; i < 4; i++) begin
      haddr = 32'((i + 1) * 4);
      htrans = i == 3 ? HTRANS_IDLE : HTRANS_SEQ;
      hsel1 = i < 3;
      #1;
      chk("burst_w1", rdy1, 0);
      nx(); #1;
      chk("burst_w2", rdy1, 0);
      nx(); #1;
      chk("burst_w3", rdy1, 0);
      nx(); #1;
      chk("burst_ready", rdy1, 1);
      chk("burst_data", hrdata1, 32'hC0DE_0000 + 32'(i));
      nx();
    end
    #1;
    chk("burst_end_ready", rdy1, 1); chk("burst_end_cs", cs1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_sram_slave_param.md
AHB_SRAM_SLAVE_PARAM -- requirements
Module: ahb_sram_slave_param

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AHB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AHB data width; legal values 32 or 64.
REQ-003 SHALL have parameter SRAM_ADDR_WIDTH, default 13, word address width of each SRAM bank.
REQ-004 SHALL have parameter NUM_BANKS, default 2, SRAM bank count; power of two, 1..8.
REQ-005 SHALL have parameter RD_LATENCY, default 1, SRAM read latency in cycles; legal range 1..3.
REQ-006 SHALL have port hclk, input, 1, the block's only clock; reset is synchronous and active-high.
REQ-007 SHALL have port hreset, input, 1, synchronous active-high reset.
REQ-008 SHALL have AHB inputs: hsel 1, haddr ADDR_WIDTH, htrans 2, hwrite 1, hsize 3, hburst 3, hwdata DATA_WIDTH, hready 1.
REQ-009 SHALL have AHB outputs: hrdata DATA_WIDTH, hresp 2 (00 OKAY, 01 ERROR), hready_resp 1.
REQ-010 SHALL have SRAM outputs: sram_cs NUM_BANKS*DATA_WIDTH/8 (one per byte lane per bank), sram_we 1, sram_addr SRAM_ADDR_WIDTH, sram_wdata DATA_WIDTH.
REQ-011 SHALL have SRAM input sram_rdata NUM_BANKS*DATA_WIDTH, concatenated bank data with bank 0 in the LSBs.

Function
REQ-012 The block SHALL capture an address phase only when hsel && hready && htrans in {NONSEQ, SEQ} at a rising hclk edge.
REQ-013 IDLE/BUSY transfers, or hsel low, SHALL get a zero-wait OKAY response and SHALL cause no SRAM access.
REQ-014 A captured transfer SHALL be flagged illegal if any of these hold: hsize > log2(DATA_WIDTH/8); haddr not aligned to hsize; haddr at or beyond NUM_BANKS*2^SRAM_ADDR_WIDTH*DATA_WIDTH/8.
REQ-015 Decode SHALL be: byte offset = haddr[log2(DATA_WIDTH/8)-1:0]; word = next SRAM_ADDR_WIDTH bits; bank = next log2(NUM_BANKS) bits.
REQ-016 The FSM SHALL have the states IDLE, WR, RD_WAIT, RD_DATA, ERR1 and ERR2.
REQ-017 On a legal write capture the FSM SHALL go to WR; in WR, for one cycle: cs of the addressed bank's active lanes = 1, sram_we = 1, sram_wdata = hwdata, hready_resp = 1, hresp = OKAY.
REQ-018 On a legal read capture the FSM SHALL go to RD_WAIT; RD_WAIT asserts cs (sram_we = 0) in its first cycle only and holds hready_resp = 0 for RD_LATENCY cycles.
REQ-019 In RD_DATA, hrdata SHALL equal the addressed bank's slice of sram_rdata, with hready_resp = 1 and hresp = OKAY; total read data phase = RD_LATENCY+1 cycles.
REQ-020 An illegal capture SHALL go to ERR1 (hresp = ERROR, hready_resp = 0), then ERR2 (hresp = ERROR, hready_resp = 1), with no SRAM access.
REQ-021 Active lanes SHALL be: all lanes for full-width transfers, otherwise 2^hsize contiguous lanes starting at the byte offset.
REQ-022 In any cycle where hready_resp = 1 (WR, RD_DATA, ERR2, IDLE), a new capture SHALL be accepted in that same cycle (pipelined), giving back-to-back transfers with no idle cycle.
REQ-023 While hready_resp = 0, new address-phase inputs SHALL be ignored; the master holds them.
REQ-024 Write-then-read of the same address SHALL return the new data; no bypass is required because the write completes before the read's SRAM access.
REQ-025 hburst SHALL be ignored; each beat is decoded from haddr, so INCR/WRAP boundary crossings into another bank are handled per beat.
REQ-026 Outside an access cycle, sram_cs SHALL be 0 and sram_we SHALL be 0; hrdata SHALL be 0 outside RD_DATA.

Reset
REQ-027 On hreset = 1 at a rising edge, the FSM SHALL go to IDLE and all captured registers SHALL clear.
REQ-028 After reset, outputs SHALL be: hready_resp = 1, hresp = 00, hrdata = 0, sram_cs = 0, sram_we = 0.
REQ-029 Reset in mid-transfer (WR, RD_WAIT, ERR1) SHALL abort it with no further SRAM access.

Structure
REQ-030 Package ahb_sram_pkg SHALL hold the htrans codes (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11), the hresp codes and the FSM state enum.
REQ-031 Lane and bank chip-select generation SHALL be in the sub-module ahb_sram_lane_dec, which is combinational and parametrised by DATA_WIDTH and NUM_BANKS.

Verification
REQ-032 Default parameters: write word 0xA5A5_1234 to 0x0000_0010, then read it back -> write zero-wait, read hready_resp low 1 cycle, hrdata = 0xA5A5_1234.
REQ-033 Byte write 0xEE to 0x0000_8003 (bank 1, offset 3) -> only bank-1 lane-3 cs asserted; word read of 0x0000_8000 shows 0xEE in bits 31:24.
REQ-034 Halfword access at 0x0000_0001 and any access at 0x0001_0000 -> ERR1/ERR2 two-cycle ERROR each, no cs asserted.
REQ-035 RD_LATENCY = 3, four-beat INCR read burst from 0x0000_0000 -> each beat 4 cycles, data matches preload.
REQ-036 Assert hreset during RD_WAIT -> next cycle state IDLE, hready_resp = 1, sram_cs = 0; a following transfer completes normally.
